fpu_addsub_param: RTL and testbench
===================================

Name: fpu_addsub_param

Overview:
Parametrised successor to the fixed 32-bit adder FPU. Performs floating-point add or subtract on a configurable sign/exponent/mantissa format, with hidden bit, single-cycle leading-zero normalisation and round-to-nearest-even. It sits between the operand registers and the result/status bus, and is driven by a start/done handshake. The result is one fixed-latency multi-cycle operation per start.

Parameters:
EXP_W, 11, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 20, stored mantissa field width (hidden bit not stored)
W, 1+EXP_W+MAN_W, total word width (derived, not overridable)

Ports:
clock_100k  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
op_sel  in  1  0 = a+b, 1 = a-b (sign of b inverted at capture)
op_a  in  W  operand a {sign, exp, mant}
op_b  in  W  operand b
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; data_out/status_out valid from this cycle
data_out  out  W  result, held until the next done
status_out  out  4  [3] exact, [2] overflow, [1] underflow, [0] inexact; held with data_out

Behaviour:
- Reset (async, reset=0): data_out=0, status_out=0, busy=0, done=0, state=IDLE. Reset mid-operation aborts the operation; no done follows.
- States: IDLE -> ALIGN -> ADD -> NORMALIZE -> ROUND -> OUTPUT -> IDLE, one cycle each.
- IDLE:
  - On start=1, latch the operands and unpack: significand = {exp!=0, mant}; exp==0 means zero (mantissa ignored, flush-to-zero).
  - Go to ALIGN. start in any other state is ignored.
- Latency: start sampled at edge N; done=1 during the cycle after edge N+5. Back-to-back: the next start is accepted in the cycle after done.
- ALIGN:
  - Swap so that operand A has the larger magnitude (compare exp, then significand).
  - Shift the smaller significand right by d = expA-expB, into a field extended by guard, round and sticky bits.
  - Sticky = OR of all bits shifted beyond R. If d >= MAN_W+3, the smaller significand becomes 0 and sticky = (it was nonzero).
- ADD:
  - Same effective sign: sum. Different sign: larger minus smaller.
  - Sum width is MAN_W+5, including carry.
  - Result sign = sign of the larger operand. Exact cancellation gives +0.
  - 0 +/- 0 gives -0 only if both effective signs are negative.
- NORMALIZE:
  - Carry set: shift right 1 (sticky ORs the lost bit), exp+1.
  - Otherwise: shift left by the leading-zero count, computed combinationally in one cycle (no iterative loop).
  - If exp-lzc <= 0: flush to signed zero; underflow=1 if the true result was nonzero.
- ROUND:
  - RNE: increment if G & (R | S | LSB).
  - Increment carrying out of the significand: shift right 1, exp+1.
  - inexact = G|R|S before rounding.
- Overflow:
  - Final exp >= 2^EXP_W-1: output signed infinity {sign, all-ones, 0}, overflow=1, inexact=1.
- Special inputs:
  - Any operand with exp all-ones is infinity. Result is infinity with that operand's effective sign; a takes precedence if both are infinite.
  - In this case overflow=1 and inexact=0.
- exact = 1 iff overflow, underflow and inexact are all 0.
- OUTPUT:
  - Register data_out = {sign, exp[EXP_W-1:0], significand without hidden bit} and status_out.
  - Pulse done, clear busy, return to IDLE.

Test Plan:
- Default params; op_a=0x3FF00000 (1.0), op_b=0x3FF00000, op_sel=0 -> data_out=0x40000000, status_out=4'b1000, done exactly 6 cycles after start.
- op_a=0x3FF80000 (1.5), op_b=0x3FF00000, op_sel=0 -> 0x40040000 (2.5), 4'b1000. Same operands with op_sel=1 -> 0x3FE00000 (0.5), 4'b1000. op_a=op_b=0x3FF00000 with op_sel=1 -> 0x00000000, 4'b1000.
- Tie case: op_a=0x3FF00000, op_b=0x3EA00000 (2^-21), add -> 0x3FF00000 (round to even), 4'b0001. op_b=0x3EA80000 (1.5*2^-21) -> 0x3FF00001, 4'b0001.
- Overflow: op_a=op_b=0x7FEFFFFF, add -> 0x7FF00000, 4'b0101. op_a=0xFFF00000 (-inf), any op_b -> 0xFFF00000, 4'b0100.
- Handshake/reset: start pulsed again during busy -> ignored, exactly one done. reset=0 asserted in ADD -> outputs 0 immediately, no done. Next start after release -> normal 6-cycle result.
- Alternate params EXP_W=8, MAN_W=23: 0x3F800000 + 0x3F800000 -> 0x40000000, 4'b1000.

Source files
------------

// File: rtl/fpu_addsub_param.sv
// Parametrised floating-point add/subtract with hidden bit, flush-to-zero,
// single-cycle leading-zero normalisation and round-to-nearest-even.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | wait for start, latch operands (b sign inverted for a-b)
// S_ALIGN   | order by magnitude, right-shift smaller into G/R/S field
// S_ADD     | add or subtract aligned significands, resolve sign
// S_NORM    | carry right-shift or leading-zero left-shift, flush check
// S_ROUND   | round to nearest even, overflow / infinity / status
// S_OUTPUT  | register result and status, pulse done
module fpu_addsub_param #(
   parameter int EXP_W = 11,
   parameter int MAN_W = 20,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clock_100k,
   input  logic         reset,
   input  logic         start,
   input  logic         op_sel,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] data_out,
   output logic [3:0]   status_out
);

   localparam int XW  = MAN_W + 4;
   localparam int SW  = MAN_W + 5;
   localparam int EW  = EXP_W + 2;
   localparam int LZW = $clog2(XW + 1);
   localparam int SHW = 2 * (MAN_W + 3);

   localparam logic [EXP_W-1:0] D_MAX    = EXP_W'(MAN_W + 3);
   localparam logic [EW-1:0]    EXP_OVF  = EW'((1 << EXP_W) - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ALIGN  = 3'd1;
   localparam logic [2:0] S_ADD    = 3'd2;
   localparam logic [2:0] S_NORM   = 3'd3;
   localparam logic [2:0] S_ROUND  = 3'd4;
   localparam logic [2:0] S_OUTPUT = 3'd5;

   logic [2:0]       state;
   logic [W-1:0]     a_r, b_r;
   logic             sign_big, sign_small, neg_zero, inf_flag, inf_sign;
   logic [EXP_W-1:0] exp_big;
   logic [XW-1:0]    x_big, x_small;
   logic [SW-1:0]    sum_r;
   logic             sign_r;
   logic [XW-1:0]    norm_r;
   logic [EW-1:0]    exp_n;
   logic             uf_r, zero_r;
   logic [W-1:0]     res_r;
   logic [3:0]       stat_r;

   // align stage signals
   logic             a_sign, b_sign, a_inf, b_inf, a_ge;
   logic [EXP_W-1:0] a_exp, b_exp, exp_big_c, exp_small_c, d_c;
   logic [MAN_W:0]   a_sig, b_sig, sig_big_c, sig_small_c;
   logic             sign_big_c, sign_small_c;
   logic [SHW-1:0]   wide_c;
   logic [MAN_W+2:0] al_c;
   logic             st_c;

   // add / normalise / round stage signals
   logic [SW-1:0]    sum_c;
   logic             sign_c;
   logic [LZW-1:0]   lz_c;
   logic [XW-1:0]    norm_c;
   logic [EW-1:0]    exp_c, exp_f;
   logic             uf_c, zero_c;
   logic             inc, inx;
   logic [MAN_W+1:0] rsig;
   logic [MAN_W-1:0] mant_c;
   logic [W-1:0]     res_c;
   logic [3:0]       stat_c;

   function automatic logic [LZW-1:0] lzc_f(input logic [XW-1:0] v);
      lzc_f = LZW'(XW);
      for (int i = 0; i < XW; i++) begin
         if (v[i]) lzc_f = LZW'(XW - 1 - i);
      end
   endfunction

   // unpack, order by magnitude and shift the smaller operand with sticky
   always_comb begin
      a_sign = a_r[W-1];
      b_sign = b_r[W-1];
      a_exp  = a_r[W-2:MAN_W];
      b_exp  = b_r[W-2:MAN_W];
      a_sig  = (a_exp != '0) ? {1'b1, a_r[MAN_W-1:0]} : '0;
      b_sig  = (b_exp != '0) ? {1'b1, b_r[MAN_W-1:0]} : '0;
      a_inf  = &a_exp;
      b_inf  = &b_exp;
      a_ge   = (a_exp > b_exp) || ((a_exp == b_exp) && (a_sig >= b_sig));
      if (a_ge) begin
         sign_big_c = a_sign;  sign_small_c = b_sign;
         exp_big_c  = a_exp;   exp_small_c  = b_exp;
         sig_big_c  = a_sig;   sig_small_c  = b_sig;
      end else begin
         sign_big_c = b_sign;  sign_small_c = a_sign;
         exp_big_c  = b_exp;   exp_small_c  = a_exp;
         sig_big_c  = b_sig;   sig_small_c  = a_sig;
      end
      d_c    = exp_big_c - exp_small_c;
      wide_c = {sig_small_c, 2'b00, {(MAN_W + 3){1'b0}}} >> d_c;
      if (d_c >= D_MAX) begin
         al_c = '0;
         st_c = |sig_small_c;
      end else begin
         al_c = wide_c[SHW-1:MAN_W+3];
         st_c = |wide_c[MAN_W+2:0];
      end
   end

   // effective add/subtract; the larger operand fixes the sign
   always_comb begin
      if (sign_big ^ sign_small) sum_c = {1'b0, x_big} - {1'b0, x_small};
      else                       sum_c = {1'b0, x_big} + {1'b0, x_small};
      sign_c = (sum_c == '0) ? neg_zero : sign_big;
   end

   // normalise: carry right-shift, or one-shot leading-zero left-shift
   always_comb begin
      lz_c   = lzc_f(sum_r[XW-1:0]);
      norm_c = '0;
      exp_c  = '0;
      uf_c   = 1'b0;
      zero_c = 1'b0;
      if (sum_r == '0) begin
         zero_c = 1'b1;
      end else if (sum_r[SW-1]) begin
         norm_c = {sum_r[SW-1:2], sum_r[1] | sum_r[0]};
         exp_c  = EW'(exp_big) + EW'(1);
      end else if (EW'(lz_c) >= EW'(exp_big)) begin
         zero_c = 1'b1;
         uf_c   = 1'b1;
      end else begin
         norm_c = sum_r[XW-1:0] << lz_c;
         exp_c  = EW'(exp_big) - EW'(lz_c);
      end
   end

   // round to nearest even, then resolve specials, overflow and status
   always_comb begin
      inc  = norm_r[2] & (norm_r[1] | norm_r[0] | norm_r[3]);
      inx  = norm_r[2] | norm_r[1] | norm_r[0];
      rsig = {1'b0, norm_r[XW-1:3]} + (MAN_W + 2)'(inc);
      if (rsig[MAN_W+1]) begin
         mant_c = rsig[MAN_W:1];
         exp_f  = exp_n + EW'(1);
      end else begin
         mant_c = rsig[MAN_W-1:0];
         exp_f  = exp_n;
      end
      if (inf_flag) begin
         res_c  = {inf_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         stat_c = 4'b0100;
      end else if (zero_r) begin
         res_c  = {sign_r, {(W - 1){1'b0}}};
         stat_c = uf_r ? 4'b0010 : 4'b1000;
      end else if (exp_f >= EXP_OVF) begin
         res_c  = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         stat_c = 4'b0101;
      end else begin
         res_c  = {sign_r, exp_f[EXP_W-1:0], mant_c};
         stat_c = inx ? 4'b0001 : 4'b1000;
      end
   end

   // sequencing and start/done handshake
   always_ff @(posedge clock_100k or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_ALIGN;
                  busy  <= 1'b1;
               end
            end
            S_ALIGN: state <= S_ADD;
            S_ADD:   state <= S_NORM;
            S_NORM:  state <= S_ROUND;
            S_ROUND: state <= S_OUTPUT;
            S_OUTPUT: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // per-stage datapath registers and the held result
   always_ff @(posedge clock_100k or negedge reset) begin
      if (!reset) begin
         a_r        <= '0;
         b_r        <= '0;
         sign_big   <= 1'b0;
         sign_small <= 1'b0;
         neg_zero   <= 1'b0;
         inf_flag   <= 1'b0;
         inf_sign   <= 1'b0;
         exp_big    <= '0;
         x_big      <= '0;
         x_small    <= '0;
         sum_r      <= '0;
         sign_r     <= 1'b0;
         norm_r     <= '0;
         exp_n      <= '0;
         uf_r       <= 1'b0;
         zero_r     <= 1'b0;
         res_r      <= '0;
         stat_r     <= '0;
         data_out   <= '0;
         status_out <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_r <= op_a;
                  b_r <= {op_b[W-1] ^ op_sel, op_b[W-2:0]};
               end
            end
            S_ALIGN: begin
               sign_big   <= sign_big_c;
               sign_small <= sign_small_c;
               exp_big    <= exp_big_c;
               x_big      <= {sig_big_c, 3'b000};
               x_small    <= {al_c, st_c};
               inf_flag   <= a_inf | b_inf;
               inf_sign   <= a_inf ? a_sign : b_sign;
               neg_zero   <= a_sign & b_sign;
            end
            S_ADD: begin
               sum_r  <= sum_c;
               sign_r <= sign_c;
            end
            S_NORM: begin
               norm_r <= norm_c;
               exp_n  <= exp_c;
               uf_r   <= uf_c;
               zero_r <= zero_c;
            end
            S_ROUND: begin
               res_r  <= res_c;
               stat_r <= stat_c;
            end
            S_OUTPUT: begin
               data_out   <= res_r;
               status_out <= stat_r;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Bench for fpu_addsub_param: default format (11/20) and single format (8/23)
// driven from the same operand bus, checked against an exact-arithmetic model.
module tb_fpu_addsub_param;

   logic        clock_100k;
   logic        reset;
   logic        start;
   logic        op_sel;
   logic [31:0] op_a, op_b;
   logic        busy0, done0, busy1, done1;
   logic [31:0] data0, data1;
   logic [3:0]  status0, status1;

   int n_vec = 0;
   int n_err = 0;

   fpu_addsub_param #(.EXP_W(11), .MAN_W(20)) dut0 (
      .clock_100k(clock_100k), .reset(reset), .start(start), .op_sel(op_sel),
      .op_a(op_a), .op_b(op_b), .busy(busy0), .done(done0),
      .data_out(data0), .status_out(status0));

   fpu_addsub_param #(.EXP_W(8), .MAN_W(23)) dut1 (
      .clock_100k(clock_100k), .reset(reset), .start(start), .op_sel(op_sel),
      .op_a(op_a), .op_b(op_b), .busy(busy1), .done(done1),
      .data_out(data1), .status_out(status1));

   initial clock_100k = 1'b0;
   always #5 clock_100k = ~clock_100k;

   // Exact value of a +/- b, rounded to nearest even; returns {status, word}.
   function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic sel, input int ew, input int mw);
      int emask, ea, eb, emin, cap, p, e, sh;
      logic sa, sb, sgn, inx;
      logic [127:0] siga, sigb, va, vb, mag, keep, rem, half, mmask;
      logic [31:0] res;
      emask = (1 << ew) - 1;
      mmask = (128'd1 << mw) - 1;
      sa = a[31];
      sb = b[31] ^ sel;
      ea = int'(a >> mw) & emask;
      eb = int'(b >> mw) & emask;
      siga = (ea == 0) ? 128'd0 : ((128'd1 << mw) | (128'(a) & mmask));
      sigb = (eb == 0) ? 128'd0 : ((128'd1 << mw) | (128'(b) & mmask));
      if (ea == emask) begin
         res = {sa, 31'd0} | (32'(emask) << mw);
         return {4'b0100, res};
      end
      if (eb == emask) begin
         res = {sb, 31'd0} | (32'(emask) << mw);
         return {4'b0100, res};
      end
      if (siga == 0 && sigb == 0) return {4'b1000, sa & sb, 31'd0};
      if (siga == 0) ea = eb;
      if (sigb == 0) eb = ea;
      // a far-away operand only matters as "something tiny and nonzero"
      cap = 2 * mw + 10;
      if (ea - eb > cap) begin
         sigb = 128'd1;
         eb = ea - cap;
      end else if (eb - ea > cap) begin
         siga = 128'd1;
         ea = eb - cap;
      end
      emin = (ea < eb) ? ea : eb;
      va = siga << (ea - emin);
      vb = sigb << (eb - emin);
      if (sa == sb) begin
         mag = va + vb; sgn = sa;
      end else if (va >= vb) begin
         mag = va - vb; sgn = sa;
      end else begin
         mag = vb - va; sgn = sb;
      end
      if (mag == 0) return {4'b1000, 32'd0};
      p = 0;
      for (int i = 0; i < 128; i++) if (mag[i]) p = i;
      e = emin + p - mw;
      if (e <= 0) return {4'b0010, sgn, 31'd0};
      if (p > mw) begin
         sh   = p - mw;
         keep = mag >> sh;
         rem  = mag & ((128'd1 << sh) - 1);
         half = 128'd1 << (sh - 1);
         inx  = (rem != 0);
         if (rem > half || (rem == half && keep[0])) keep = keep + 1;
         if (keep[mw+1]) begin
            keep = keep >> 1;
            e = e + 1;
         end
      end else begin
         keep = mag << (mw - p);
         inx = 1'b0;
      end
      if (e >= emask) begin
         res = {sgn, 31'd0} | (32'(emask) << mw);
         return {4'b0101, res};
      end
      res = {sgn, 31'd0} | (32'(e) << mw) | 32'(keep & mmask);
      return {inx ? 4'b0001 : 4'b1000, res};
   endfunction

   function automatic logic [31:0] rand_op(input int base_e);
      int pick, e;
      pick = int'($urandom_range(0, 19));
      if (pick == 0)       e = 0;
      else if (pick == 1)  e = 2047;
      else if (pick <= 4)  e = int'($urandom_range(1, 4));
      else if (pick <= 6)  e = int'($urandom_range(2040, 2046));
      else if (pick <= 12) e = base_e + int'($urandom_range(0, 6)) - 3;
      else                 e = int'($urandom_range(1, 2046));
      if (e < 1 && pick > 0) e = 1;
      if (e > 2046 && pick != 1) e = 2046;
      return {1'($urandom_range(0, 1)), 11'(e), 20'($urandom)};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sel,
                         output logic [31:0] d0, output logic [3:0] s0,
                         output logic [31:0] d1, output logic [3:0] s1,
                         output int lat, output logic done_sync);
      @(negedge clock_100k);
      op_a = a; op_b = b; op_sel = sel; start = 1'b1;
      @(posedge clock_100k); #1;
      start = 1'b0;
      lat = -1;
      done_sync = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clock_100k); #1;
         if (done0) begin
            lat = i;
            done_sync = done1;
            break;
         end
      end
      d0 = data0; s0 = status0; d1 = data1; s1 = status1;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
      #23;
      n_vec++;
      if ({busy0, done0, data0, status0} !== 38'd0) begin
         n_err++;
         $display("FAIL reset_dut0: busy=%b done=%b data=%h status=%b, want all zero",
                  busy0, done0, data0, status0);
      end
      n_vec++;
      if ({busy1, done1, data1, status1} !== 38'd0) begin
         n_err++;
         $display("FAIL reset_dut1: busy=%b done=%b data=%h status=%b, want all zero",
                  busy1, done1, data1, status1);
      end
      @(negedge clock_100k);
      reset = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] ta [0:11] = '{32'h3FF00000, 32'h3FF80000, 32'h3FF80000, 32'h3FF00000,
                                 32'h3FF00000, 32'h3FF00000, 32'h7FEFFFFF, 32'hFFF00000,
                                 32'h80000000, 32'h00000000, 32'h00180000, 32'h3FF00000};
      logic [31:0] tb [0:11] = '{32'h3FF00000, 32'h3FF00000, 32'h3FF00000, 32'h3FF00000,
                                 32'h3EA00000, 32'h3EA80000, 32'h7FEFFFFF, 32'h3FF00000,
                                 32'h80000000, 32'h00000000, 32'h00100000, 32'h7FF00000};
      logic        ts [0:11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] td [0:11] = '{32'h40000000, 32'h40040000, 32'h3FE00000, 32'h00000000,
                                 32'h3FF00000, 32'h3FF00001, 32'h7FF00000, 32'hFFF00000,
                                 32'h80000000, 32'h00000000, 32'h00000000, 32'hFFF00000};
      logic [3:0]  tt [0:11] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001,
                                 4'b0101, 4'b0100, 4'b1000, 4'b1000, 4'b0010, 4'b0100};
      logic [31:0] d0, d1;
      logic [3:0]  s0, s1;
      logic [35:0] m1;
      logic        ds;
      int          lat;
      for (int i = 0; i < 12; i++) begin
         run_op(ta[i], tb[i], ts[i], d0, s0, d1, s1, lat, ds);
         n_vec++;
         if (lat !== 5 || ds !== 1'b1) begin
            n_err++;
            $display("FAIL dir_latency[%0d]: got %0d edges (dut1 done=%b), want 5 with both done",
                     i, lat, ds);
         end
         n_vec++;
         if (d0 !== td[i] || s0 !== tt[i]) begin
            n_err++;
            $display("FAIL dir_result[%0d]: a=%h b=%h sel=%b got %h/%b want %h/%b",
                     i, ta[i], tb[i], ts[i], d0, s0, td[i], tt[i]);
         end
         m1 = ref_model(ta[i], tb[i], ts[i], 8, 23);
         n_vec++;
         if ({s1, d1} !== m1) begin
            n_err++;
            $display("FAIL dir_alt[%0d]: got %h/%b want %h/%b", i, d1, s1, m1[31:0], m1[35:32]);
         end
      end
   endtask

   task automatic test_alt_params();
      logic [31:0] d0, d1;
      logic [3:0]  s0, s1;
      logic [35:0] m0;
      logic        ds;
      int          lat;
      run_op(32'h3F800000, 32'h3F800000, 1'b0, d0, s0, d1, s1, lat, ds);
      n_vec++;
      if (d1 !== 32'h40000000 || s1 !== 4'b1000) begin
         n_err++;
         $display("FAIL alt_one_plus_one: got %h/%b want 40000000/1000", d1, s1);
      end
      m0 = ref_model(32'h3F800000, 32'h3F800000, 1'b0, 11, 20);
      n_vec++;
      if ({s0, d0} !== m0) begin
         n_err++;
         $display("FAIL alt_pattern_dut0: got %h/%b want %h/%b", d0, s0, m0[31:0], m0[35:32]);
      end
   endtask

   task automatic test_random(input int count);
      logic [31:0] a, b, d0, d1;
      logic [3:0]  s0, s1;
      logic [35:0] m0, m1;
      logic        sel, ds;
      int          lat;
      for (int i = 0; i < count; i++) begin
         a   = rand_op(1023);
         b   = rand_op(int'(a[30:20]));
         sel = 1'($urandom_range(0, 1));
         run_op(a, b, sel, d0, s0, d1, s1, lat, ds);
         m0 = ref_model(a, b, sel, 11, 20);
         m1 = ref_model(a, b, sel, 8, 23);
         n_vec++;
         if (lat !== 5 || ds !== 1'b1 || {s0, d0} !== m0) begin
            n_err++;
            $display("FAIL rand_dut0[%0d]: a=%h b=%h sel=%b lat=%0d got %h/%b want %h/%b",
                     i, a, b, sel, lat, d0, s0, m0[31:0], m0[35:32]);
         end
         n_vec++;
         if ({s1, d1} !== m1) begin
            n_err++;
            $display("FAIL rand_dut1[%0d]: a=%h b=%h sel=%b got %h/%b want %h/%b",
                     i, a, b, sel, d1, s1, m1[31:0], m1[35:32]);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int          ndone;
      logic [31:0] got;
      @(negedge clock_100k);
      op_a = 32'h3FF80000; op_b = 32'h3FF00000; op_sel = 1'b0; start = 1'b1;
      @(posedge clock_100k); #1;
      start = 1'b0;
      ndone = 0;
      got = '0;
      for (int i = 1; i <= 14; i++) begin
         @(posedge clock_100k); #1;
         if (i == 2) begin
            op_a = 32'h40000000; op_b = 32'h40100000; op_sel = 1'b1; start = 1'b1;
         end
         if (i == 3) start = 1'b0;
         if (done0) begin
            ndone++;
            got = data0;
         end
         if (i <= 5) begin
            n_vec++;
            if (busy0 !== (i < 5)) begin
               n_err++;
               $display("FAIL busy_level[%0d]: got %b want %b", i, busy0, (i < 5));
            end
         end
      end
      n_vec++;
      if (ndone !== 1) begin
         n_err++;
         $display("FAIL busy_done_count: got %0d done pulses want 1", ndone);
      end
      n_vec++;
      if (got !== 32'h40040000) begin
         n_err++;
         $display("FAIL busy_result: got %h want 40040000", got);
      end
   endtask

   task automatic test_reset_abort();
      int          ndone;
      logic [31:0] d0, d1;
      logic [3:0]  s0, s1;
      logic        ds;
      int          lat;
      @(negedge clock_100k);
      op_a = 32'h3FF00000; op_b = 32'h3FF00000; op_sel = 1'b0; start = 1'b1;
      @(posedge clock_100k); #1;
      start = 1'b0;
      @(posedge clock_100k); #1;
      reset = 1'b0;
      #1;
      n_vec++;
      if ({busy0, done0, data0, status0} !== 38'd0 || {busy1, done1, data1, status1} !== 38'd0) begin
         n_err++;
         $display("FAIL abort_outputs: dut0 %b/%b/%h/%b dut1 %b/%b/%h/%b want all zero",
                  busy0, done0, data0, status0, busy1, done1, data1, status1);
      end
      @(negedge clock_100k);
      reset = 1'b1;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock_100k); #1;
         if (done0 || done1) ndone++;
      end
      n_vec++;
      if (ndone !== 0) begin
         n_err++;
         $display("FAIL abort_no_done: got %0d done cycles want 0", ndone);
      end
      run_op(32'h3FF80000, 32'h3FF00000, 1'b1, d0, s0, d1, s1, lat, ds);
      n_vec++;
      if (lat !== 5 || d0 !== 32'h3FE00000 || s0 !== 4'b1000) begin
         n_err++;
         $display("FAIL abort_recover: lat=%0d got %h/%b want 5 3fe00000/1000", lat, d0, s0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, d0, d1;
      logic [3:0]  s0, s1;
      logic [35:0] m0;
      logic        ds;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         a = rand_op(1023);
         b = rand_op(int'(a[30:20]));
         run_op(a, b, 1'(i), d0, s0, d1, s1, lat, ds);
         m0 = ref_model(a, b, 1'(i), 11, 20);
         n_vec++;
         if (lat !== 5 || {s0, d0} !== m0) begin
            n_err++;
            $display("FAIL b2b[%0d]: lat=%0d got %h/%b want 5 %h/%b",
                     i, lat, d0, s0, m0[31:0], m0[35:32]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_alt_params();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      test_random(300);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
